// File: rtl/trdb_pkg.sv
// trdb_pkg
//   Shared types and constants for the trace debugger packet streaming path.
//   TRDB_PACKET_W       : width of one packet word from trace_debugger (32)
//   trdb_word_t         : one packet word
//   trdb_stream_state_e : serializer FSM states (S_IDLE, S_SEND)
package trdb_pkg;

  localparam int TRDB_PACKET_W = 32;

  typedef logic [TRDB_PACKET_W-1:0] trdb_word_t;

  typedef enum logic {
    S_IDLE,
    S_SEND
  } trdb_stream_state_e;

endpackage

// File: rtl/trdb_sync_fifo.sv
// trdb_sync_fifo
//   Single-clock FIFO with a first-word-fall-through head output. The
//   pointers carry one extra MSB so that full and empty can be told apart
//   when the address bits are equal.
// Ports
//   clk_i, rst_i : clock, asynchronous active-high reset
//   flush_i      : synchronous clear; wins over push and pop
//   push_i       : write data_i (ignored when full unless popping this cycle)
//   data_i       : word to write
//   pop_i        : drop head (ignored when empty)
//   data_o       : current head word
//   full_o       : DEPTH words stored
//   empty_o      : no words stored
//   level_o      : number of words stored
module trdb_sync_fifo
  import trdb_pkg::*;
#(
  parameter int  DEPTH  = 16,
  parameter type data_t = trdb_word_t
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  data_t                      data_i,
  input  logic                       pop_i,
  output data_t                      data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  data_t       mem_q [DEPTH];
  logic        do_push;
  logic        do_pop;

  // A full FIFO may still accept a word when its head leaves in the same cycle.
  always_comb begin
    do_pop  = pop_i & ~empty_o & ~flush_i;
    do_push = push_i & (~full_o | do_pop) & ~flush_i;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + 1'b1;
      if (do_pop)  rptr_d = rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage needs no reset; the pointers define which entries are valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= data_i;
  end

  assign data_o  = mem_q[rptr_q[AW-1:0]];
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign level_o = wptr_q - rptr_q;

endmodule

// File: rtl/trdb_packet_streamer.sv
// trdb_packet_streamer
//   Captures packet words from trace_debugger (no backpressure), buffers
//   them in a FIFO and serializes each 32-bit word LSB-first into PORT_W-bit
//   beats on a valid/ready trace port. Words arriving while the FIFO is full
//   are dropped and flagged by the sticky overflow_o.
// Optional feature macro: TRDB_STREAMER_DROP_CNT_EN adds drop_cnt_o, a
//   saturating 16-bit count of dropped words.
// Ports
//   clk_i, rst_i         : clock, asynchronous active-high reset
//   enable_i             : 0 ignores incoming words (draining continues)
//   flush_i              : synchronous clear of FIFO, serializer and overflow
//   packet_word_i/_valid_i : incoming word and its single-cycle qualifier
//   trace_data_o/_valid_o/_last_o, trace_ready_i : beat output port
//   fifo_level_o         : words waiting in the FIFO (not the serializer)
//   overflow_o           : sticky drop indication
//   drop_cnt_o           : dropped word count (macro builds only)
module trdb_packet_streamer
  import trdb_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int PORT_W = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     enable_i,
  input  logic                     flush_i,
  input  logic [TRDB_PACKET_W-1:0] packet_word_i,
  input  logic                     packet_word_valid_i,
  output logic [PORT_W-1:0]        trace_data_o,
  output logic                     trace_valid_o,
  output logic                     trace_last_o,
  input  logic                     trace_ready_i,
  output logic [$clog2(DEPTH):0]   fifo_level_o,
  output logic                     overflow_o
`ifdef TRDB_STREAMER_DROP_CNT_EN
  ,
  output logic [15:0]              drop_cnt_o
`endif
);

  localparam int BEATS = TRDB_PACKET_W / PORT_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  trdb_stream_state_e state_q, state_d;
  trdb_word_t         shreg_q, shreg_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic               overflow_q, overflow_d;
`ifdef TRDB_STREAMER_DROP_CNT_EN
  logic [15:0]        drop_cnt_q, drop_cnt_d;
`endif

  logic       push_req;
  logic       fifo_pop;
  logic       fifo_full;
  logic       fifo_empty;
  trdb_word_t fifo_head;
  logic       handshake;
  logic       last_beat;
  logic       drop;

  assign push_req = packet_word_valid_i & enable_i & ~flush_i;

  trdb_sync_fifo #(
    .DEPTH  (DEPTH),
    .data_t (trdb_word_t)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .push_i  (push_req),
    .data_i  (packet_word_i),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level_o)
  );

  // Serializer FSM: IDLE loads the FIFO head; SEND shifts out one beat per
  // handshake and, on the last beat, reloads straight from the FIFO so that
  // consecutive words stream without a bubble.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    beat_cnt_d = beat_cnt_q;
    overflow_d = overflow_q;
    fifo_pop   = 1'b0;
    drop       = 1'b0;

    trace_valid_o = (state_q == S_SEND);
    last_beat     = (beat_cnt_q == LAST_BEAT);
    handshake     = trace_valid_o & trace_ready_i;
    trace_last_o  = trace_valid_o & last_beat;
    trace_data_o  = trace_valid_o ? shreg_q[PORT_W-1:0] : '0;

    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          shreg_d    = fifo_head;
          beat_cnt_d = '0;
          state_d    = S_SEND;
        end
      end
      S_SEND: begin
        if (handshake) begin
          if (last_beat) begin
            beat_cnt_d = '0;
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
              shreg_d  = fifo_head;
            end else begin
              shreg_d = '0;
              state_d = S_IDLE;
            end
          end else begin
            shreg_d    = shreg_q >> PORT_W;
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A word is lost only when the FIFO is full and no room opens this cycle.
    drop = push_req & fifo_full & ~fifo_pop;
    if (drop) overflow_d = 1'b1;

    if (flush_i) begin
      state_d    = S_IDLE;
      shreg_d    = '0;
      beat_cnt_d = '0;
      overflow_d = 1'b0;
      fifo_pop   = 1'b0;
    end
  end

`ifdef TRDB_STREAMER_DROP_CNT_EN
  // Saturating drop counter, cleared together with overflow_o.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (flush_i) begin
      drop_cnt_d = '0;
    end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) drop_cnt_q <= '0;
    else       drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt_o = drop_cnt_q;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      shreg_q    <= '0;
      beat_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      beat_cnt_q <= beat_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_trdb_packet_streamer.sv
// tb_trdb_packet_streamer
//   Self-checking bench for trdb_packet_streamer (DEPTH=4, PORT_W=8).
//   Directed scenarios plus a randomized stream compared against a queue of
//   accepted words expanded into LSB-first byte beats.
//   Builds with or without TRDB_STREAMER_DROP_CNT_EN.
module tb_trdb_packet_streamer;
  import trdb_pkg::*;

  localparam int DEPTH  = 4;
  localparam int PORT_W = 8;
  localparam int BEATS  = 32 / PORT_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              enable;
  logic              flush;
  logic [31:0]       pktWord;
  logic              pktValid;
  logic [PORT_W-1:0] trData;
  logic              trValid;
  logic              trLast;
  logic              ready;
  logic [$clog2(DEPTH):0] level;
  logic              overflow;
`ifdef TRDB_STREAMER_DROP_CNT_EN
  logic [15:0]       dropCnt;
`endif

  int assertCount = 0;
  int failCount   = 0;

  logic [PORT_W:0] obsQ[$];
  int              wordsDone = 0;
  int              obsRd = 0;

  trdb_packet_streamer #(.DEPTH(DEPTH), .PORT_W(PORT_W)) dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .enable_i            (enable),
    .flush_i             (flush),
    .packet_word_i       (pktWord),
    .packet_word_valid_i (pktValid),
    .trace_data_o        (trData),
    .trace_valid_o       (trValid),
    .trace_last_o        (trLast),
    .trace_ready_i       (ready),
    .fifo_level_o        (level),
    .overflow_o          (overflow)
`ifdef TRDB_STREAMER_DROP_CNT_EN
    ,
    .drop_cnt_o          (dropCnt)
`endif
  );

  always #5 clk = ~clk;

  // Record every accepted beat half a cycle before the edge that takes it.
  always @(negedge clk) begin
    if (!rst && trValid && ready) begin
      obsQ.push_back({trLast, trData});
      if (trLast) wordsDone++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int needBeats, input int maxCycles, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < maxCycles; c++) begin
      if (obsQ.size() - obsRd >= needBeats) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (obsQ.size() - obsRd >= needBeats) ok = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; flush = 1'b0; pktWord = '0; pktValid = 1'b0; ready = 1'b0;
    step(); step();
    assertCount++; if (trValid !== 1'b0) begin failCount++; $display("[TB] FAIL reset_valid: got %0b expected 0", trValid); end
    assertCount++; if (trData !== '0) begin failCount++; $display("[TB] FAIL reset_data: got %h expected 00", trData); end
    assertCount++; if (trLast !== 1'b0) begin failCount++; $display("[TB] FAIL reset_last: got %0b expected 0", trLast); end
    assertCount++; if (level !== '0) begin failCount++; $display("[TB] FAIL reset_level: got %0d expected 0", level); end
    assertCount++; if (overflow !== 1'b0) begin failCount++; $display("[TB] FAIL reset_overflow: got %0b expected 0", overflow); end
    rst = 1'b0;
    step();
    assertCount++; if (trValid !== 1'b0) begin failCount++; $display("[TB] FAIL reset_release_valid: got %0b expected 0", trValid); end
  endtask

  task automatic test_single_word();
    logic [31:0] w;
    w = 32'hA1B2C3D4;
    ready = 1'b1; pktWord = w; pktValid = 1'b1;
    step();
    pktValid = 1'b0;
    assertCount++; if (trValid !== 1'b0) begin failCount++; $display("[TB] FAIL single_early_valid: got %0b expected 0", trValid); end
    assertCount++; if (level !== 3'd1) begin failCount++; $display("[TB] FAIL single_level: got %0d expected 1", level); end
    step();
    for (int i = 0; i < BEATS; i++) begin
      assertCount++; if (trValid !== 1'b1) begin failCount++; $display("[TB] FAIL single_valid beat %0d: got %0b expected 1", i, trValid); end
      assertCount++; if (trData !== w[8*i +: 8]) begin failCount++; $display("[TB] FAIL single_data beat %0d: got %h expected %h", i, trData, w[8*i +: 8]); end
      assertCount++; if (trLast !== (i == BEATS-1)) begin failCount++; $display("[TB] FAIL single_last beat %0d: got %0b expected %0b", i, trLast, (i == BEATS-1)); end
      step();
    end
    assertCount++; if (trValid !== 1'b0) begin failCount++; $display("[TB] FAIL single_idle: got %0b expected 0", trValid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w[2];
    logic [31:0] cur;
    w[0] = $urandom; w[1] = $urandom;
    ready = 1'b1;
    pktWord = w[0]; pktValid = 1'b1; step();
    pktWord = w[1]; step();
    pktValid = 1'b0;
    for (int i = 0; i < 2*BEATS; i++) begin
      cur = w[i/BEATS];
      assertCount++; if (trValid !== 1'b1) begin failCount++; $display("[TB] FAIL b2b_valid beat %0d: got %0b expected 1", i, trValid); end
      assertCount++; if (trData !== cur[8*(i%BEATS) +: 8]) begin failCount++; $display("[TB] FAIL b2b_data beat %0d: got %h expected %h", i, trData, cur[8*(i%BEATS) +: 8]); end
      assertCount++; if (trLast !== ((i%BEATS) == BEATS-1)) begin failCount++; $display("[TB] FAIL b2b_last beat %0d: got %0b", i, trLast); end
      step();
    end
    assertCount++; if (trValid !== 1'b0) begin failCount++; $display("[TB] FAIL b2b_idle: got %0b expected 0", trValid); end
  endtask

  task automatic test_stall();
    logic [31:0] w;
    w = $urandom;
    obsRd = obsQ.size();
    ready = 1'b1; pktWord = w; pktValid = 1'b1; step();
    pktValid = 1'b0; step();
    step();
    ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      assertCount++; if (trValid !== 1'b1) begin failCount++; $display("[TB] FAIL stall_valid cycle %0d: got %0b expected 1", c, trValid); end
      assertCount++; if (trData !== w[15:8]) begin failCount++; $display("[TB] FAIL stall_data cycle %0d: got %h expected %h", c, trData, w[15:8]); end
      step();
    end
    ready = 1'b1;
    for (int i = 1; i < BEATS; i++) begin
      assertCount++; if (trData !== w[8*i +: 8]) begin failCount++; $display("[TB] FAIL stall_resume beat %0d: got %h expected %h", i, trData, w[8*i +: 8]); end
      step();
    end
    assertCount++; if (obsQ.size() - obsRd !== BEATS) begin failCount++; $display("[TB] FAIL stall_beat_count: got %0d expected %0d", obsQ.size() - obsRd, BEATS); end
    for (int i = 0; i < BEATS && obsRd < obsQ.size(); i++) begin
      assertCount++; if (obsQ[obsRd] !== {(i == BEATS-1), w[8*i +: 8]}) begin failCount++; $display("[TB] FAIL stall_stream beat %0d: got %h expected %h", i, obsQ[obsRd], {(i == BEATS-1), w[8*i +: 8]}); end
      obsRd++;
    end
  endtask

  task automatic test_overflow();
    logic [31:0] w[6];
    logic [31:0] cur;
    bit ok;
    obsRd = obsQ.size();
    ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      w[i] = $urandom;
      pktWord = w[i]; pktValid = 1'b1; step();
    end
    pktValid = 1'b0; step();
    assertCount++; if (level !== 3'd4) begin failCount++; $display("[TB] FAIL ovf_level: got %0d expected 4", level); end
    assertCount++; if (overflow !== 1'b1) begin failCount++; $display("[TB] FAIL ovf_flag: got %0b expected 1", overflow); end
`ifdef TRDB_STREAMER_DROP_CNT_EN
    assertCount++; if (dropCnt !== 16'd1) begin failCount++; $display("[TB] FAIL ovf_drop_cnt: got %0d expected 1", dropCnt); end
`endif
    assertCount++; if (trData !== w[0][7:0]) begin failCount++; $display("[TB] FAIL ovf_head: got %h expected %h", trData, w[0][7:0]); end
    ready = 1'b1;
    drain(5*BEATS, 200, ok);
    step(); step();
    assertCount++; if (!ok) begin failCount++; $display("[TB] FAIL ovf_drain_timeout: got %0d beats expected %0d", obsQ.size() - obsRd, 5*BEATS); end
    assertCount++; if (obsQ.size() - obsRd !== 5*BEATS) begin failCount++; $display("[TB] FAIL ovf_beat_count: got %0d expected %0d", obsQ.size() - obsRd, 5*BEATS); end
    for (int i = 0; i < 5*BEATS && obsRd < obsQ.size(); i++) begin
      cur = w[i/BEATS];
      assertCount++; if (obsQ[obsRd] !== {((i%BEATS) == BEATS-1), cur[8*(i%BEATS) +: 8]}) begin failCount++; $display("[TB] FAIL ovf_stream beat %0d: got %h expected %h", i, obsQ[obsRd], {((i%BEATS) == BEATS-1), cur[8*(i%BEATS) +: 8]}); end
      obsRd++;
    end
    assertCount++; if (overflow !== 1'b1) begin failCount++; $display("[TB] FAIL ovf_sticky: got %0b expected 1", overflow); end
    assertCount++; if (level !== '0) begin failCount++; $display("[TB] FAIL ovf_drained_level: got %0d expected 0", level); end
  endtask

  task automatic test_flush();
    logic [31:0] w;
    ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pktWord = $urandom; pktValid = 1'b1; step();
    end
    pktValid = 1'b0;
    assertCount++; if (level !== 3'd3) begin failCount++; $display("[TB] FAIL flush_pre_level: got %0d expected 3", level); end
    ready = 1'b1; step();
    flush = 1'b1; pktWord = 32'hDEADBEEF; pktValid = 1'b1;
    step();
    flush = 1'b0; pktValid = 1'b0;
    assertCount++; if (trValid !== 1'b0) begin failCount++; $display("[TB] FAIL flush_valid: got %0b expected 0", trValid); end
    assertCount++; if (level !== '0) begin failCount++; $display("[TB] FAIL flush_level: got %0d expected 0", level); end
    assertCount++; if (overflow !== 1'b0) begin failCount++; $display("[TB] FAIL flush_overflow: got %0b expected 0", overflow); end
`ifdef TRDB_STREAMER_DROP_CNT_EN
    assertCount++; if (dropCnt !== 16'd0) begin failCount++; $display("[TB] FAIL flush_drop_cnt: got %0d expected 0", dropCnt); end
`endif
    step(); step();
    assertCount++; if (trValid !== 1'b0) begin failCount++; $display("[TB] FAIL flush_discard: got %0b expected 0", trValid); end
    w = $urandom;
    pktWord = w; pktValid = 1'b1; step();
    pktValid = 1'b0; step();
    for (int i = 0; i < BEATS; i++) begin
      assertCount++; if (trValid !== 1'b1 || trData !== w[8*i +: 8]) begin failCount++; $display("[TB] FAIL flush_restream beat %0d: got %0b/%h expected 1/%h", i, trValid, trData, w[8*i +: 8]); end
      step();
    end
    obsRd = obsQ.size();
  endtask

  task automatic test_async_reset();
    logic [31:0] w;
    ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pktWord = $urandom; pktValid = 1'b1; step();
    end
    pktValid = 1'b0;
    #2 rst = 1'b1;
    #1;
    assertCount++; if (trValid !== 1'b0) begin failCount++; $display("[TB] FAIL arst_valid: got %0b expected 0", trValid); end
    assertCount++; if (trData !== '0) begin failCount++; $display("[TB] FAIL arst_data: got %h expected 00", trData); end
    assertCount++; if (level !== '0) begin failCount++; $display("[TB] FAIL arst_level: got %0d expected 0", level); end
    #2 rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      assertCount++; if (trValid !== 1'b0 || level !== '0) begin failCount++; $display("[TB] FAIL arst_residue cycle %0d: got valid %0b level %0d expected 0/0", c, trValid, level); end
    end
    w = $urandom;
    pktWord = w; pktValid = 1'b1; step();
    pktValid = 1'b0; step();
    for (int i = 0; i < BEATS; i++) begin
      assertCount++; if (trValid !== 1'b1 || trData !== w[8*i +: 8]) begin failCount++; $display("[TB] FAIL arst_restream beat %0d: got %0b/%h expected 1/%h", i, trValid, trData, w[8*i +: 8]); end
      step();
    end
    obsRd = obsQ.size();
  endtask

  task automatic test_random();
    logic [31:0] expQ[$];
    logic [31:0] cur;
    int doneBase;
    bit ok;
    obsRd = obsQ.size();
    doneBase = wordsDone;
    for (int c = 0; c < 400; c++) begin
      ready  = ($urandom_range(0, 3) != 0);
      enable = ($urandom_range(0, 4) != 0);
      pktValid = 1'b0;
      if ((expQ.size() - (wordsDone - doneBase) < DEPTH) && ($urandom_range(0, 2) == 0)) begin
        pktWord = $urandom;
        pktValid = 1'b1;
        if (enable) expQ.push_back(pktWord);
      end
      step();
    end
    pktValid = 1'b0; enable = 1'b1; ready = 1'b1;
    drain(expQ.size()*BEATS, 400, ok);
    step(); step();
    assertCount++; if (!ok) begin failCount++; $display("[TB] FAIL rand_drain_timeout: got %0d beats expected %0d", obsQ.size() - obsRd, expQ.size()*BEATS); end
    assertCount++; if (obsQ.size() - obsRd !== expQ.size()*BEATS) begin failCount++; $display("[TB] FAIL rand_beat_count: got %0d expected %0d", obsQ.size() - obsRd, expQ.size()*BEATS); end
    for (int i = 0; i < expQ.size()*BEATS && obsRd < obsQ.size(); i++) begin
      cur = expQ[i/BEATS];
      assertCount++; if (obsQ[obsRd] !== {((i%BEATS) == BEATS-1), cur[8*(i%BEATS) +: 8]}) begin failCount++; $display("[TB] FAIL rand_stream beat %0d: got %h expected %h", i, obsQ[obsRd], {((i%BEATS) == BEATS-1), cur[8*(i%BEATS) +: 8]}); end
      obsRd++;
    end
    assertCount++; if (overflow !== 1'b0) begin failCount++; $display("[TB] FAIL rand_overflow: got %0b expected 0", overflow); end
    assertCount++; if (trValid !== 1'b0 || level !== '0) begin failCount++; $display("[TB] FAIL rand_idle: got valid %0b level %0d expected 0/0", trValid, level); end
  endtask

  initial begin
    $display("[TB] starting trdb_packet_streamer bench");
    test_reset();
    test_single_word();
    test_back_to_back();
    test_stall();
    test_overflow();
    test_flush();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
